// File: rtl/simple_system_f2sdram_arb_pkg.sv
// Shared types and width helpers for the f2sdram master command-stream arbiter.
//   state_e     : arbiter FSM state (IDLE, GRANT)
//   idx_w       : width of a channel index (at least 1 bit)
//   beat_cnt_w  : width of a beat counter that must reach max_burst
//   ptr_w       : width of a FIFO read/write pointer for a power-of-two depth
package simple_system_f2sdram_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam int unsigned DefaultNumIn     = 2;
  localparam int unsigned DefaultDataW     = 8;
  localparam int unsigned DefaultFifoDepth = 4;
  localparam int unsigned DefaultMaxBurst  = 4;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned beat_cnt_w(input int unsigned max_burst);
    return (max_burst > 0) ? $clog2(max_burst + 1) : 1;
  endfunction

  function automatic int unsigned ptr_w(input int unsigned depth);
    return idx_w(depth);
  endfunction

endpackage

// File: rtl/simple_system_f2sdram_arb_fifo.sv
// Single-channel synchronous FIFO used to absorb one non-stallable producer.
//   clk_i, reset_i : clock, synchronous active-high reset
//   push_i, data_i : write strobe and byte; ignored when full unless popped too
//   pop_i          : read strobe; ignored when empty
//   head_o         : oldest entry (valid when !empty_o)
//   count_o        : occupancy
//   empty_o, full_o: status flags
module simple_system_f2sdram_arb_fifo
  import simple_system_f2sdram_arb_pkg::*;
#(
  parameter int unsigned DataW = 8,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = ptr_w(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [DataW-1:0] data_i,
  input  logic             pop_i,
  output logic [DataW-1:0] head_o,
  output logic [CntW-1:0]  count_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [DataW-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign do_pop  = pop_i & ~empty_o;
  // A full FIFO still takes a push when the same cycle frees a slot.
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Storage needs no reset; occupancy alone defines what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/simple_system_f2sdram_master_st_arbiter.sv
// Round-robin arbiter merging NUM_IN byte producers onto one Avalon-ST stream.
//   clk, reset      : clock, synchronous active-high reset
//   in_valid/in_data: per-channel byte strobes (never stalled), channel i at
//                     in_data[i*DATA_W +: DATA_W]
//   out_valid/out_data/out_channel/out_ready : shared Avalon-ST source
//   overflow        : sticky per-channel drop flags
//   clear_overflow  : per-channel clear strobes (a same-cycle set wins)
module simple_system_f2sdram_master_st_arbiter
  import simple_system_f2sdram_arb_pkg::*;
#(
  parameter int unsigned NUM_IN     = DefaultNumIn,
  parameter int unsigned DATA_W     = DefaultDataW,
  parameter int unsigned FIFO_DEPTH = DefaultFifoDepth,
  parameter int unsigned MAX_BURST  = DefaultMaxBurst,
  localparam int unsigned ChW       = idx_w(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_IN-1:0]        in_valid,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [ChW-1:0]           out_channel,
  input  logic                     out_ready,
  output logic [NUM_IN-1:0]        overflow,
  input  logic [NUM_IN-1:0]        clear_overflow
);

  localparam int unsigned CntW  = ptr_w(FIFO_DEPTH) + 1;
  localparam int unsigned BeatW = beat_cnt_w(MAX_BURST);

  logic [NUM_IN-1:0] fifo_pop, fifo_empty, fifo_full;
  logic [DATA_W-1:0] fifo_head  [NUM_IN];
  logic [CntW-1:0]   fifo_count [NUM_IN];

  state_e            state_q, state_d;
  logic [ChW-1:0]    grant_q, grant_d, last_grant_q, last_grant_d;
  logic [BeatW-1:0]  beat_cnt_q, beat_cnt_d;
  logic [NUM_IN-1:0] overflow_q, overflow_d;
  logic [ChW-1:0]    sel_idx, cand;
  logic              sel_found, beat, burst_done;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_fifo
    simple_system_f2sdram_arb_fifo #(
      .DataW(DATA_W),
      .Depth(FIFO_DEPTH)
    ) u_fifo (
      .clk_i  (clk),
      .reset_i(reset),
      .push_i (in_valid[i]),
      .data_i (in_data[i*DATA_W +: DATA_W]),
      .pop_i  (fifo_pop[i]),
      .head_o (fifo_head[i]),
      .count_o(fifo_count[i]),
      .empty_o(fifo_empty[i]),
      .full_o (fifo_full[i])
    );
  end

  // Search starts just after the last grant so every channel gets a turn.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_IN; k++) begin
      cand = ChW'((32'(last_grant_q) + k) % NUM_IN);
      if (!sel_found && !fifo_empty[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    out_valid   = 1'b0;
    out_data    = '0;
    out_channel = '0;
    fifo_pop    = '0;
    if (state_q == GRANT) begin
      out_valid   = ~fifo_empty[grant_q];
      out_data    = out_valid ? fifo_head[grant_q] : '0;
      out_channel = grant_q;
      fifo_pop[grant_q] = out_valid & out_ready;
    end
  end

  assign beat = out_valid & out_ready;
  // Burst ends at the beat limit or when this beat drains the FIFO; a push
  // landing on the same cycle keeps the FIFO non-empty.
  assign burst_done = beat &&
                      ((32'(beat_cnt_q) + 32'd1 == MAX_BURST) ||
                       (fifo_count[grant_q] == CntW'(1) && !in_valid[grant_q]));

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d      = GRANT;
          grant_d      = sel_idx;
          last_grant_d = sel_idx;
          beat_cnt_d   = '0;
        end
      end
      GRANT: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q + BeatW'(1);
          if (burst_done) state_d = IDLE;
        end
      end
    endcase
  end

  // Drop = push into a full FIFO that is not popped this cycle; set beats clear.
  assign overflow_d = (overflow_q & ~clear_overflow) | (in_valid & fifo_full & ~fifo_pop);
  assign overflow   = overflow_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= ChW'(NUM_IN - 1);
      beat_cnt_q   <= '0;
      overflow_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      overflow_q   <= overflow_d;
    end
  end

endmodule

// File: tb/tb_simple_system_f2sdram_master_st_arbiter.sv
// Randomised and directed checks of the f2sdram stream arbiter against a
// queue-based reference model.
module tb_simple_system_f2sdram_master_st_arbiter;

  localparam int unsigned NI    = 2;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXB  = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [NI-1:0]    in_valid, clear_overflow, overflow;
  logic [NI*DW-1:0] in_data;
  logic             out_valid, out_ready;
  logic [DW-1:0]    out_data;
  logic [0:0]       out_channel;

  always #5 clk = ~clk;

  simple_system_f2sdram_master_st_arbiter #(
    .NUM_IN    (NI),
    .DATA_W    (DW),
    .FIFO_DEPTH(DEPTH),
    .MAX_BURST (MAXB)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_channel   (out_channel),
    .out_ready     (out_ready),
    .overflow      (overflow),
    .clear_overflow(clear_overflow)
  );

  // Reference model: one queue per channel plus "who holds the stream".
  typedef logic [7:0] byteq_t [$];
  byteq_t        mq [NI];
  bit            m_busy;
  int            m_g, m_last, m_beats;
  logic [NI-1:0] m_ov;
  int            beat_log [$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) mq[i].delete();
    m_busy  = 1'b0;
    m_g     = 0;
    m_last  = NI - 1;
    m_beats = 0;
    m_ov    = '0;
  endtask

  // Advance the model across one clock edge with the given inputs.
  task automatic model_step(input logic [NI-1:0] iv, input logic [NI*DW-1:0] id,
                            input logic rdy, input logic [NI-1:0] clr, input logic rst);
    int            sel;
    bit            did_beat;
    logic [NI-1:0] drop;
    if (rst) begin
      model_reset();
      return;
    end
    sel = -1;
    if (!m_busy) begin
      for (int k = 1; k <= NI; k++) begin
        int c;
        c = (m_last + k) % NI;
        if (sel < 0 && mq[c].size() > 0) sel = c;
      end
    end
    did_beat = m_busy && mq[m_g].size() > 0 && rdy;
    if (did_beat) begin
      void'(mq[m_g].pop_front());
      m_beats++;
    end
    drop = '0;
    for (int i = 0; i < NI; i++) begin
      if (iv[i]) begin
        if (mq[i].size() < DEPTH) mq[i].push_back(id[i*DW +: DW]);
        else drop[i] = 1'b1;
      end
    end
    m_ov = (m_ov & ~clr) | drop;
    if (m_busy) begin
      if (did_beat && (m_beats == MAXB || mq[m_g].size() == 0)) m_busy = 1'b0;
    end else if (sel >= 0) begin
      m_busy  = 1'b1;
      m_g     = sel;
      m_last  = sel;
      m_beats = 0;
    end
  endtask

  // One cycle: compare outputs with the model, then drive new inputs.
  task automatic step(input logic [NI-1:0] iv, input logic [NI*DW-1:0] id, input logic rdy,
                      input logic [NI-1:0] clr, input logic rst);
    logic       ev;
    logic [7:0] ed;
    @(negedge clk);
    ev = m_busy && mq[m_g].size() > 0;
    ed = ev ? mq[m_g][0] : 8'h00;
    check("out_valid", 32'(out_valid), 32'(ev));
    check("out_data", 32'(out_data), 32'(ed));
    check("out_channel", 32'(out_channel), 32'(m_busy ? m_g : 0));
    check("overflow", 32'(overflow), 32'(m_ov));
    if (out_valid && rdy) beat_log.push_back(int'(out_channel));
    in_valid       = iv;
    in_data        = id;
    out_ready      = rdy;
    clear_overflow = clr;
    reset          = rst;
    model_step(iv, id, rdy, clr, rst);
  endtask

  logic [NI-1:0] iv;
  int            pushed [NI];
  int            exp_order [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1};

  initial begin
    in_valid       = '0;
    in_data        = '0;
    out_ready      = 1'b0;
    clear_overflow = '0;
    reset          = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_channel", 32'(out_channel), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);

    // Single byte latency: push in cycle 0, visible in cycle 2, idle in cycle 3.
    step(2'b10, 16'hA500, 1'b1, 2'b00, 1'b0);
    step(2'b00, 16'h0000, 1'b1, 2'b00, 1'b0);
    step(2'b00, 16'h0000, 1'b1, 2'b00, 1'b0);
    check("a5_valid", 32'(out_valid), 32'd1);
    check("a5_data", 32'(out_data), 32'h0000_00A5);
    check("a5_channel", 32'(out_channel), 32'd1);
    step(2'b00, 16'h0000, 1'b1, 2'b00, 1'b0);
    check("a5_idle", 32'(dut.state_q), 32'd0);
    check("a5_valid_gone", 32'(out_valid), 32'd0);

    // Two channels with 6 bytes each, bursts of MAXB.
    step('0, '0, 1'b0, '0, 1'b1);
    beat_log.delete();
    pushed[0] = 0;
    pushed[1] = 0;
    for (int c = 0; c < 80 && beat_log.size() < 12; c++) begin
      iv = '0;
      for (int i = 0; i < NI; i++) begin
        if (pushed[i] < 6 && mq[i].size() < DEPTH) begin
          iv[i] = 1'b1;
          pushed[i]++;
        end
      end
      step(iv, 16'($urandom), 1'b1, 2'b00, 1'b0);
    end
    check("burst_beats", 32'(beat_log.size()), 32'd12);
    for (int k = 0; k < 12 && k < beat_log.size(); k++) begin
      check("burst_order", 32'(beat_log[k]), 32'(exp_order[k]));
    end

    // Backpressure mid-burst: one beat, then 5 stalled cycles.
    step('0, '0, 1'b0, '0, 1'b1);
    for (int c = 0; c < 4; c++) step(2'b01, 16'(8'h10 + c), 1'b0, 2'b00, 1'b0);
    step(2'b00, 16'h0000, 1'b1, 2'b00, 1'b0);
    for (int c = 0; c < 5; c++) begin
      step(2'b00, 16'h0000, 1'b0, 2'b00, 1'b0);
      check("stall_beat_cnt", 32'(dut.beat_cnt_q), 32'd1);
    end
    for (int c = 0; c < 6; c++) step(2'b00, 16'h0000, 1'b1, 2'b00, 1'b0);

    // Overflow: 5 pushes while stalled, clear, then set-and-clear together.
    step('0, '0, 1'b0, '0, 1'b1);
    for (int c = 0; c < 5; c++) step(2'b01, 16'(8'h20 + c), 1'b0, 2'b00, 1'b0);
    step(2'b00, 16'h0000, 1'b0, 2'b00, 1'b0);
    check("ovf_set", 32'(overflow), 32'd1);
    step(2'b00, 16'h0000, 1'b0, 2'b01, 1'b0);
    step(2'b00, 16'h0000, 1'b0, 2'b00, 1'b0);
    check("ovf_clear", 32'(overflow), 32'd0);
    step(2'b01, 16'h0077, 1'b0, 2'b01, 1'b0);
    step(2'b00, 16'h0000, 1'b0, 2'b00, 1'b0);
    check("ovf_set_wins", 32'(overflow), 32'd1);
    step(2'b00, 16'h0000, 1'b0, 2'b01, 1'b0);

    // Full FIFO popped and pushed in the same cycle keeps the byte.
    step(2'b01, 16'h003C, 1'b1, 2'b00, 1'b0);
    step(2'b00, 16'h0000, 1'b0, 2'b00, 1'b0);
    check("fullpop_ovf", 32'(overflow), 32'd0);
    check("fullpop_count", 32'(dut.g_fifo[0].u_fifo.count_q), 32'd4);
    for (int c = 0; c < 8; c++) step(2'b00, 16'h0000, 1'b1, 2'b00, 1'b0);

    // Reset in the middle of a burst with 3 bytes buffered.
    for (int c = 0; c < 3; c++) step(2'b10, 16'(16'h3000 + (c << 8)), 1'b0, 2'b00, 1'b0);
    step(2'b00, 16'h0000, 1'b0, 2'b00, 1'b1);
    step(2'b00, 16'h0000, 1'b0, 2'b00, 1'b0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_fifo0", 32'(dut.g_fifo[0].u_fifo.count_q), 32'd0);
    check("mid_rst_fifo1", 32'(dut.g_fifo[1].u_fifo.count_q), 32'd0);
    step(2'b11, 16'h5A5A, 1'b0, 2'b00, 1'b0);
    step(2'b00, 16'h0000, 1'b0, 2'b00, 1'b0);
    step(2'b00, 16'h0000, 1'b0, 2'b00, 1'b0);
    check("post_rst_valid", 32'(out_valid), 32'd1);
    check("post_rst_channel", 32'(out_channel), 32'd0);

    // Random traffic with occasional clears and resets.
    for (int c = 0; c < 3000; c++) begin
      step(NI'($urandom_range(0, 3)), 16'($urandom), $urandom_range(0, 3) != 0,
           ($urandom_range(0, 15) == 0) ? NI'($urandom_range(1, 3)) : '0,
           $urandom_range(0, 499) == 0);
    end
    step('0, '0, 1'b1, '0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
